// File: rtl/pearson_pkg.sv
// Shared definitions for the Pearson hash checker: permutation table,
// FSM state encoding and default length-counter width.
// Optional feature macro used by the top: PEARSON_ERRCNT_EN.
package pearson_pkg;

    localparam int unsigned LEN_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [255:0][7:0] table_t;

    // Identity permutation; kept as a table so a different permutation
    // only needs this function changed.
    function automatic table_t build_table();
        table_t t;
        for (int unsigned i = 0; i < 256; i++) begin
            t[i] = 8'(i);
        end
        return t;
    endfunction

    localparam table_t PEARSON_T = build_table();

endpackage

// File: rtl/pearson_lut.sv
// Combinational Pearson permutation lookup: 8-bit index -> table entry.
module pearson_lut
    import pearson_pkg::*;
(
    input  logic [7:0] idx,
    output logic [7:0] entry
);

    // Table read
    always_comb begin
        entry = PEARSON_T[idx];
    end

endmodule

// File: rtl/pearson_hash_check.sv
// Pearson hash checker: hashes message bytes, compares against the trailing
// tag byte, and holds the result until consumed.
// Optional macro PEARSON_ERRCNT_EN adds err_cnt, a saturating count of
// consumed results whose res_match was 0.
module pearson_hash_check
    import pearson_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_match,
    output logic [7:0]       res_hash,
    output logic [LEN_W-1:0] res_len,
    output logic             res_ovf
`ifdef PEARSON_ERRCNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_e           state_q, state_d;
    logic [7:0]       hash_q, hash_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             res_match_q, res_match_d;
    logic [7:0]       res_hash_q, res_hash_d;
    logic [LEN_W-1:0] res_len_q, res_len_d;
    logic             res_ovf_q, res_ovf_d;
    logic [7:0]       lut_idx;
    logic [7:0]       lut_entry;
    logic             accept;

    // The running hash is not cleared between frames, so the first byte of
    // a frame indexes with a zero seed instead of the stale hash.
    always_comb begin
        lut_idx = ((state_q == IDLE) ? 8'h00 : hash_q) ^ in_data;
    end

    pearson_lut u_lut (
        .idx   (lut_idx),
        .entry (lut_entry)
    );

    // Next-state, datapath and handshake outputs
    always_comb begin
        state_d     = state_q;
        hash_d      = hash_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        res_match_d = res_match_q;
        res_hash_d  = res_hash_q;
        res_len_d   = res_len_q;
        res_ovf_d   = res_ovf_q;
        in_ready    = (state_q != DONE);
        res_valid   = (state_q == DONE);
        accept      = in_valid && in_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_last) begin
                        hash_d  = lut_entry;
                        len_d   = LEN_W'(1);
                        ovf_d   = 1'b0;
                        state_d = MSG;
                    end else begin
                        hash_d      = '0;
                        len_d       = '0;
                        ovf_d       = 1'b0;
                        res_hash_d  = '0;
                        res_len_d   = '0;
                        res_ovf_d   = 1'b0;
                        res_match_d = (in_data == 8'h00);
                        state_d     = DONE;
                    end
                end
            end
            MSG: begin
                if (accept) begin
                    if (!in_last) begin
                        hash_d = lut_entry;
                        if (len_q == LEN_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            len_d = len_q + LEN_W'(1);
                        end
                    end else begin
                        res_hash_d  = hash_q;
                        res_len_d   = len_q;
                        res_ovf_d   = ovf_q;
                        res_match_d = (hash_q == in_data) && !ovf_q;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hash_q      <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            res_match_q <= 1'b0;
            res_hash_q  <= '0;
            res_len_q   <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hash_q      <= hash_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            res_match_q <= res_match_d;
            res_hash_q  <= res_hash_d;
            res_len_q   <= res_len_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign res_match = res_match_q;
    assign res_hash  = res_hash_q;
    assign res_len   = res_len_q;
    assign res_ovf   = res_ovf_q;

`ifdef PEARSON_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Count consumed mismatching results, saturating
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (res_valid && res_ready && !res_match_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pearson_hash_check.sv
// Scoreboard bench for pearson_hash_check: two instances (default LEN_W and
// LEN_W=3) share one stimulus stream; a monitor checks results, latency,
// hold stability and reset behaviour.
module tb_pearson_hash_check;

    typedef struct {
        logic [7:0] hash;
        logic [7:0] len;
        logic       ovf;
        logic       match;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       res_ready;
    logic       in_ready_a, res_valid_a, res_match_a, res_ovf_a;
    logic [7:0] res_hash_a, res_len_a;
    logic       in_ready_b, res_valid_b, res_match_b, res_ovf_b;
    logic [7:0] res_hash_b;
    logic [2:0] res_len_b;
`ifdef PEARSON_ERRCNT_EN
    logic [15:0] err_cnt_a, err_cnt_b;
    int          model_err = 0;
`endif

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   checks = 0;
    int   errors = 0;
    logic stim_done = 1'b0;
    logic tag_pending = 1'b0;

    always #5 clk = ~clk;

    pearson_hash_check u_dut_a (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready_a),
        .res_valid (res_valid_a),
        .res_ready (res_ready),
        .res_match (res_match_a),
        .res_hash  (res_hash_a),
        .res_len   (res_len_a),
        .res_ovf   (res_ovf_a)
`ifdef PEARSON_ERRCNT_EN
        ,
        .err_cnt   (err_cnt_a)
`endif
    );

    pearson_hash_check #(.LEN_W(3)) u_dut_b (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready_b),
        .res_valid (res_valid_b),
        .res_ready (res_ready),
        .res_match (res_match_b),
        .res_hash  (res_hash_b),
        .res_len   (res_len_b),
        .res_ovf   (res_ovf_b)
`ifdef PEARSON_ERRCNT_EN
        ,
        .err_cnt   (err_cnt_b)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: all comparisons happen on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid_a", int'(res_valid_a), 0);
            check("rst_valid_b", int'(res_valid_b), 0);
            check("rst_ready_a", int'(in_ready_a), 1);
            check("rst_ready_b", int'(in_ready_b), 1);
            check("rst_match_a", int'(res_match_a), 0);
            check("rst_hash_a", int'(res_hash_a), 0);
            check("rst_len_a", int'(res_len_a), 0);
            tag_pending = 1'b0;
`ifdef PEARSON_ERRCNT_EN
            model_err = 0;
            check("rst_errcnt_a", int'(err_cnt_a), 0);
`endif
        end else begin
`ifdef PEARSON_ERRCNT_EN
            check("errcnt_a", int'(err_cnt_a), model_err);
`endif
            if (tag_pending) begin
                check("latency_valid_a", int'(res_valid_a), 1);
                check("latency_valid_b", int'(res_valid_b), 1);
            end
            check("valid_b_eq_a", int'(res_valid_b), int'(res_valid_a));
            if (res_valid_a) begin
                check("done_ready_a", int'(in_ready_a), 0);
                check("done_ready_b", int'(in_ready_b), 0);
                if (exp_a.size() == 0 || exp_b.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("hash_a", int'(res_hash_a), int'(exp_a[0].hash));
                    check("len_a", int'(res_len_a), int'(exp_a[0].len));
                    check("ovf_a", int'(res_ovf_a), int'(exp_a[0].ovf));
                    check("match_a", int'(res_match_a), int'(exp_a[0].match));
                    check("hash_b", int'(res_hash_b), int'(exp_b[0].hash));
                    check("len_b", int'(res_len_b), int'(exp_b[0].len));
                    check("ovf_b", int'(res_ovf_b), int'(exp_b[0].ovf));
                    check("match_b", int'(res_match_b), int'(exp_b[0].match));
                    if (res_ready) begin
`ifdef PEARSON_ERRCNT_EN
                        if (!exp_a[0].match) model_err++;
`endif
                        void'(exp_a.pop_front());
                        void'(exp_b.pop_front());
                    end
                end
            end else begin
                check("idle_ready_a", int'(in_ready_a), 1);
                check("idle_ready_b", int'(in_ready_b), 1);
            end
            tag_pending = in_valid && in_ready_a && in_last;
        end
        if (stim_done) begin
            check("drain_a", exp_a.size(), 0);
            check("drain_b", exp_b.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // Present one byte and hold it until accepted
    task automatic send(input logic [7:0] b, input logic last);
        logic ok;
        int   guard;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        guard    = 0;
        do begin
            @(negedge clk);
            ok = in_ready_a;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 50);
        if (!ok) begin
            $display("FAIL send_timeout act=0 exp=1");
            $fatal(1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push(input logic [7:0] ha, input logic [7:0] la, input logic oa, input logic ma,
                        input logic [7:0] hb, input logic [7:0] lb, input logic ob, input logic mb);
        exp_a.push_back('{ha, la, oa, ma});
        exp_b.push_back('{hb, lb, ob, mb});
    endtask

    initial begin
        logic [7:0] m1 [8];
        int         guard;
        m1 = '{8'd47, 8'd17, 8'd48, 8'd12, 8'd26, 8'd28, 8'd40, 8'd21};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Known-good tag; LEN_W=3 instance overflows on the 8th byte
        for (int i = 0; i < 8; i++) send(m1[i], 1'b0);
        push(8'd57, 8'd8, 1'b0, 1'b1, 8'd57, 8'd7, 1'b1, 1'b0);
        send(8'd57, 1'b1);

        // Wrong tag
        for (int i = 0; i < 8; i++) send(m1[i], 1'b0);
        push(8'd57, 8'd8, 1'b0, 1'b0, 8'd57, 8'd7, 1'b1, 1'b0);
        send(8'd58, 1'b1);

        // Tag-only frame
        push(8'h00, 8'd0, 1'b0, 1'b1, 8'h00, 8'd0, 1'b0, 1'b1);
        send(8'h00, 1'b1);

        // Eight 0x01 bytes: hash 0, overflow only for LEN_W=3
        for (int i = 0; i < 8; i++) send(8'h01, 1'b0);
        push(8'h00, 8'd8, 1'b0, 1'b1, 8'h00, 8'd7, 1'b1, 1'b0);
        send(8'h00, 1'b1);

        // Result held 5 cycles with input pressure, then released
        send(8'h3C, 1'b0);
        push(8'h3C, 8'd1, 1'b0, 1'b1, 8'h3C, 8'd1, 1'b0, 1'b1);
        res_ready = 1'b0;
        send(8'h3C, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b0;
        repeat (5) @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h04, 1'b0);
        push(8'h07, 8'd3, 1'b0, 1'b1, 8'h07, 8'd3, 1'b0, 1'b1);
        send(8'h07, 1'b1);

        // Reset mid-frame discards the partial frame
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'h05, 1'b0);
        push(8'h05, 8'd1, 1'b0, 1'b1, 8'h05, 8'd1, 1'b0, 1'b1);
        send(8'h05, 1'b1);

        guard = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        #1 stim_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/pearson_hash_check.md
PEARSON_HASH_CHECK -- requirements
Module: pearson_hash_check

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of the message-length counter; max message length 2^LEN_W-1 bytes.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: in_data/in_last valid.
REQ-005 SHALL have port in_data, input, 8: message byte, or tag byte when in_last=1.
REQ-006 SHALL have port in_last, input, 1: current byte is the received hash tag and ends the frame.
REQ-007 SHALL have port in_ready, output, 1: byte accepted when in_valid && in_ready.
REQ-008 SHALL have port res_valid, output, 1: result valid, held until res_ready.
REQ-009 SHALL have port res_ready, input, 1: result consumed when res_valid && res_ready.
REQ-010 SHALL have port res_match, output, 1: computed hash equals tag and no overflow.
REQ-011 SHALL have port res_hash, output, 8: computed Pearson hash of message bytes.
REQ-012 SHALL have port res_len, output, LEN_W: message byte count, excluding tag.
REQ-013 SHALL have port res_ovf, output, 1: message exceeded 2^LEN_W-1 bytes.

Function
REQ-014 SHALL implement FSM states IDLE, MSG, DONE.
REQ-015 IDLE: in_ready=1; accepted byte with in_last=0 -> hash=T[0^in_data], len=1, go MSG; with in_last=1 -> empty message, hash=0, len=0, go DONE.
REQ-016 MSG: in_ready=1; accepted byte with in_last=0 -> hash=T[hash^in_data], len+1; with in_last=1 -> compare, go DONE.
REQ-017 One byte per cycle; no bubbles required; in_valid low stalls without state change.
REQ-018 Tag byte never enters the hash; res_match=(hash==tag)&&!ovf, registered on tag acceptance.
REQ-019 res_valid SHALL be 1 in the cycle after tag acceptance (latency 1) and in all DONE cycles.
REQ-020 DONE: in_ready=0; res_* stable; res_valid&&res_ready -> IDLE next cycle.
REQ-021 Length overflow: message byte accepted with len=2^LEN_W-1 -> len saturates, sticky ovf=1, hashing continues; frame still ends on in_last.
REQ-022 T = fixed 256-entry permutation, T[i]=i; 8-bit XOR index, no widening.
REQ-023 res_valid=0 outside DONE; res_match/res_hash/res_len/res_ovf keep last frame value until next tag acceptance.

Reset
REQ-024 reset low SHALL asynchronously force state=IDLE, hash=0, len=0, ovf=0, res_match=0, res_valid=0; in_ready=1 after release.
REQ-025 Reset mid-frame SHALL discard the partial frame; no result issued.

Configuration
REQ-026 Macro PEARSON_ERRCNT_EN defined: output err_cnt[15:0] SHALL count results with res_match=0 at res_valid&&res_ready, saturating at 16'hFFFF, reset to 0; undefined: port and counter absent, function otherwise identical.

Structure
REQ-027 Shared package pearson_pkg SHALL hold the table T, the FSM state encoding (2 bits) and the default LEN_W.
REQ-028 Sub-module pearson_lut (combinational, 8-bit index -> 8-bit T entry) SHALL be instantiated once.

Verification
REQ-029 Bytes 47,17,48,12,26,28,40,21 then tag 57 (in_last) -> res_valid 1 cycle later, res_hash=57, res_len=8, res_match=1.
REQ-030 Same message, tag 58 -> res_match=0, res_hash=57; with PEARSON_ERRCNT_EN, err_cnt 0->1 after res_ready.
REQ-031 Single byte 0x00 with in_last (tag only) -> res_len=0, res_hash=0, res_match=1.
REQ-032 LEN_W=3, 8 message bytes of 0x01 then tag 0x00 -> res_len=7, res_ovf=1, res_match=0.
REQ-033 Result held with res_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable; res_ready=1 -> IDLE, next frame accepted next cycle.
REQ-034 reset low after 3 message bytes -> res_valid=0, in_ready=1 after release; new frame 0x05, tag 0x05 -> res_match=1, res_len=1.
